// File: rtl/multi_port_mem.sv
// Single-clock RAM shared by NUM_PORTS read/write ports. When several ports write the
// same address in one cycle, the lowest-index port wins. Reads take 1 or 2 cycles.
module multi_port_mem #(
  parameter int WIDTH        = 12,
  parameter int ADDR_WIDTH   = 10,
  parameter int NUM_PORTS    = 4,
  parameter int READ_LATENCY = 1,
  parameter int RDW_MODE     = 0
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic [NUM_PORTS-1:0]            i_en,
  input  logic [NUM_PORTS-1:0]            i_we,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] i_addr,
  input  logic [NUM_PORTS*WIDTH-1:0]      i_din,
  output logic [NUM_PORTS*WIDTH-1:0]      o_dout,
  output logic [NUM_PORTS-1:0]            o_valid,
  output logic [NUM_PORTS-1:0]            o_wr_collision
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  generate
    if ((READ_LATENCY != 1) && (READ_LATENCY != 2)) begin : g_bad_latency
      $error("multi_port_mem: READ_LATENCY must be 1 or 2");
    end
    if ((NUM_PORTS < 1) || (NUM_PORTS > 8)) begin : g_bad_ports
      $error("multi_port_mem: NUM_PORTS must be in 1..8");
    end
  endgenerate

  logic [WIDTH-1:0]           mem_q [DEPTH];
  logic [NUM_PORTS-1:0]       wr_req_s;
  logic [NUM_PORTS-1:0]       rd_req_s;
  logic [NUM_PORTS-1:0]       wr_win_s;
  logic [NUM_PORTS-1:0]       wr_lose_s;
  logic                       hit_s;
  logic [NUM_PORTS*WIDTH-1:0] rd_data_s;

  logic [NUM_PORTS-1:0]       rd_valid_q, rd_valid_d;
  logic [NUM_PORTS-1:0]       coll_q, coll_d;
  logic [NUM_PORTS*WIDTH-1:0] rd_data_q, rd_data_d;

  // A write loses if any lower-index port writes the same address this cycle.
  always_comb begin
    wr_req_s  = i_en & i_we;
    rd_req_s  = i_en & ~i_we;
    wr_win_s  = '0;
    wr_lose_s = '0;
    hit_s     = 1'b0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      hit_s = 1'b0;
      for (int q = 0; q < p; q++) begin
        hit_s = hit_s | (wr_req_s[q] &&
                (i_addr[q*ADDR_WIDTH +: ADDR_WIDTH] == i_addr[p*ADDR_WIDTH +: ADDR_WIDTH]));
      end
      wr_win_s[p]  = wr_req_s[p] & ~hit_s;
      wr_lose_s[p] = wr_req_s[p] & hit_s;
    end
  end

  // Read data: array contents, optionally bypassed by another port's winning write.
  always_comb begin
    rd_data_s = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      rd_data_s[p*WIDTH +: WIDTH] = mem_q[i_addr[p*ADDR_WIDTH +: ADDR_WIDTH]];
      for (int q = 0; q < NUM_PORTS; q++) begin
        rd_data_s[p*WIDTH +: WIDTH] =
          ((RDW_MODE == 1) && (q != p) && wr_win_s[q] &&
           (i_addr[q*ADDR_WIDTH +: ADDR_WIDTH] == i_addr[p*ADDR_WIDTH +: ADDR_WIDTH]))
          ? i_din[q*WIDTH +: WIDTH] : rd_data_s[p*WIDTH +: WIDTH];
      end
    end
  end

  // The array has no reset, so its contents survive i_rst_n.
  always_ff @(posedge i_clk) begin
    if (i_rst_n) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (wr_win_s[p]) begin
          mem_q[i_addr[p*ADDR_WIDTH +: ADDR_WIDTH]] <= i_din[p*WIDTH +: WIDTH];
        end
      end
    end
  end

  // First read stage. Each data slice holds its value until that port reads again.
  always_comb begin
    rd_valid_d = rd_req_s;
    coll_d     = wr_lose_s;
    rd_data_d  = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      rd_data_d[p*WIDTH +: WIDTH] = rd_req_s[p] ? rd_data_s[p*WIDTH +: WIDTH]
                                                : rd_data_q[p*WIDTH +: WIDTH];
    end
  end

  // First-stage registers; reset flushes in-flight reads and ignores the current access.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      rd_valid_q <= '0;
      coll_q     <= '0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= rd_valid_d;
      coll_q     <= coll_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign o_wr_collision = coll_q;

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic [NUM_PORTS-1:0]       out_valid_q;
      logic [NUM_PORTS*WIDTH-1:0] out_data_q, out_data_d;

      // Output stage loads only when a completed read arrives from the first stage.
      always_comb begin
        out_data_d = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
          out_data_d[p*WIDTH +: WIDTH] = rd_valid_q[p] ? rd_data_q[p*WIDTH +: WIDTH]
                                                       : out_data_q[p*WIDTH +: WIDTH];
        end
      end

      // Extra output register for the two-cycle latency.
      always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
          out_valid_q <= '0;
          out_data_q  <= '0;
        end else begin
          out_valid_q <= rd_valid_q;
          out_data_q  <= out_data_d;
        end
      end

      assign o_valid = out_valid_q;
      assign o_dout  = out_data_q;
    end else begin : g_lat1
      assign o_valid = rd_valid_q;
      assign o_dout  = rd_data_q;
    end
  endgenerate

endmodule
